// File: rtl/sdram_req_sched.sv
// sdram_req_sched: burst-level round-robin scheduler in front of sdram_ctrl.
// Grants one full burst at a time and steers address, write data and acks
// between the granted requester and the controller.
// Optional build macro SDRAM_SCHED_PRIO0_EN: port 0 gets strict priority and
// the remaining ports rotate among themselves.
module sdram_req_sched #(
   parameter int PORTS        = 3,
   parameter int BURST_LENGTH = 8
) (
   input  logic                  sdram_clk,
   input  logic                  sdram_rst_n,
   input  logic [PORTS-1:0]      req_i,
   input  logic [PORTS-1:0]      req_we_i,
   input  logic [PORTS*32-1:0]   req_adr_i,
   input  logic [PORTS*16-1:0]   req_dat_i,
   input  logic [PORTS*2-1:0]    req_sel_i,
   output logic [PORTS-1:0]      req_ack_o,
   output logic [PORTS-1:0]      done_o,
   output logic [PORTS-1:0]      gnt_o,
   output logic [15:0]           dat_o,
   input  logic                  sdram_idle_i,
   output logic                  acc_o,
   output logic                  we_o,
   output logic [31:0]           adr_o,
   output logic [1:0]            sel_o,
   output logic [15:0]           sdram_dat_o,
   input  logic [15:0]           sdram_dat_i,
   input  logic                  ack_i
);

   localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   gnt_idx;
   logic [2:0]      beat;
   logic            aband_q;

   logic            busy;
   logic            aband;
   logic            last_beat;
   logic [PORTS-1:0] req_rr;
   logic            rr_vld;
   logic [PW-1:0]   rr_idx;
   logic            win_vld;
   logic [PW-1:0]   win_idx;

   assign busy      = (state == BUSY);
   // Once the owner drops its request the rest of the burst is a dummy run.
   assign aband     = aband_q | ~req_i[gnt_idx];
   assign last_beat = (beat == 3'(BURST_LENGTH - 1));
   assign dat_o     = sdram_dat_i;

`ifdef SDRAM_SCHED_PRIO0_EN
   assign req_rr = req_i & ~PORTS'(1);
`else
   assign req_rr = req_i;
`endif

   // Round-robin search: first requester at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      rr_vld = 1'b0;
      rr_idx = '0;
      idx    = 0;
      for (int k = PORTS - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % PORTS;
         if (req_rr[idx]) begin
            rr_vld = 1'b1;
            rr_idx = PW'(idx);
         end
      end
   end

   // Final winner selection, with port 0 overriding when prioritised.
   always_comb begin
      win_vld = rr_vld;
      win_idx = rr_idx;
`ifdef SDRAM_SCHED_PRIO0_EN
      if (req_i[0]) begin
         win_vld = 1'b1;
         win_idx = '0;
      end
`endif
   end

   // Beat-level steering: acks, byte selects and write data for the owner.
   always_comb begin
      req_ack_o   = '0;
      sel_o       = 2'b00;
      sdram_dat_o = 16'h0000;
      if (busy) begin
         sdram_dat_o = req_dat_i[int'(gnt_idx)*16 +: 16];
         if (!aband) begin
            sel_o              = req_sel_i[int'(gnt_idx)*2 +: 2];
            req_ack_o[gnt_idx] = ack_i;
         end
      end
   end

   // Burst FSM: grant, count beats, pulse done and advance the rotation.
   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         gnt_idx <= '0;
         beat    <= '0;
         aband_q <= 1'b0;
         gnt_o   <= '0;
         done_o  <= '0;
         acc_o   <= 1'b0;
         we_o    <= 1'b0;
         adr_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_o <= '0;
               if (win_vld && sdram_idle_i) begin
                  gnt_idx <= win_idx;
                  gnt_o   <= PORTS'(1) << win_idx;
                  adr_o   <= req_adr_i[int'(win_idx)*32 +: 32];
                  we_o    <= req_we_i[win_idx];
                  acc_o   <= 1'b1;
                  aband_q <= 1'b0;
                  beat    <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (!req_i[gnt_idx])
                  aband_q <= 1'b1;
               if (ack_i) begin
                  if (last_beat) begin
                     state           <= DONE;
                     acc_o           <= 1'b0;
                     we_o            <= 1'b0;
                     gnt_o           <= '0;
                     beat            <= '0;
                     done_o[gnt_idx] <= ~aband;
`ifdef SDRAM_SCHED_PRIO0_EN
                     if (gnt_idx != '0) begin
`else
                     begin
`endif
                        if (int'(gnt_idx) == PORTS - 1)
                           rr_ptr <= '0;
                        else
                           rr_ptr <= gnt_idx + 1'b1;
                     end
                  end else begin
                     beat <= beat + 3'd1;
                  end
               end
            end
            DONE: begin
               done_o <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sdram_req_sched.md
# sdram_req_sched

Burst-level request scheduler sharing the internal SDRAM controller interface (acc/adr/we/sel/dat/ack/idle) among PORTS requesters. Sits in the sdram_clk domain between the per-port buffers and sdram_ctrl. Grants one full burst at a time, round-robin, and steers address, write data and acks for the granted port. It contains no clock-domain crossing; all requesters are synchronous to sdram_clk.

## Interface
- PORTS, 3, number of requesters (2..8)
- BURST_LENGTH, 8, 16-bit beats per granted access; legal values 1, 2, 4, 8
- sdram_clk  in  1  sole clock
- sdram_rst_n  in  1  asynchronous active-low reset
- req_i  in  PORTS  per-port burst request; held until done_o for that port
- req_we_i  in  PORTS  per-port write enable
- req_adr_i  in  PORTS*32  per-port burst start address
- req_dat_i  in  PORTS*16  per-port write data, current beat
- req_sel_i  in  PORTS*2  per-port byte selects, current beat
- req_ack_o  out  PORTS  per-port beat ack (read data valid / write data consumed)
- done_o  out  PORTS  one-cycle pulse, burst complete
- gnt_o  out  PORTS  one-hot grant, registered
- dat_o  out  16  read data broadcast to all ports (sdram dat_i pass-through)
- sdram_idle_i  in  1  controller idle
- acc_o, we_o  out  1 each  controller access / write
- adr_o  out  32  controller address
- sel_o  out  2  controller byte selects
- sdram_dat_o  out  16  controller write data
- sdram_dat_i  in  16  controller read data
- ack_i  in  1  controller beat ack

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE; gnt_o=0, acc_o=0, we_o=0, adr_o=0, sel_o=0, sdram_dat_o=0, req_ack_o=0, done_o=0, rr pointer=0, beat=0.
- IDLE: if any req_i and sdram_idle_i, pick winner = first requesting port at or after rr pointer (wrapping). Register gnt_o, latch adr_o/we_o from winner; go BUSY. If no request or sdram_idle_i=0, stay.
- BUSY: acc_o=1. adr_o/we_o held from latch; sel_o/sdram_dat_o combinationally muxed from granted port. On each ack_i: req_ack_o[gnt]=1 same cycle, beat increments. On ack_i with beat==BURST_LENGTH-1: go DONE.
- DONE: acc_o=0, done_o[gnt]=1 for one cycle, rr pointer = gnt index+1 mod PORTS, gnt_o cleared, beat=0; next IDLE.
- Abandoned request (req_i[gnt] drops during BUSY): burst still runs to completion (controller cannot abort); req_ack_o and done_o for that port suppressed; sel_o forced 2'b00 on remaining write beats.
- ack_i outside BUSY ignored. beat counter 3 bits, no wrap beyond BURST_LENGTH-1.
- Fairness: any continuously requesting port is granted within PORTS-1 other bursts.

## Timing
- Request-to-acc_o: 1 cycle (req_i and sdram_idle_i sampled high at edge N, acc_o high after edge N+1... i.e. visible during cycle N+1).
- Last ack_i at edge M: acc_o low and done_o high during cycle M+1; new grant earliest at edge M+2 (requires sdram_idle_i).
- req_ack_o is combinational from ack_i (zero latency); dat_o is combinational pass-through.
- Asynchronous reset mid-burst: all outputs return to reset values immediately; no done_o issued.

## Configuration
- SDRAM_SCHED_PRIO0_EN defined: port 0 has strict priority — whenever req_i[0] is high in IDLE it wins; remaining ports round-robin among themselves; rr pointer not advanced by port 0 grants. Port 0 may starve others.
- Undefined: pure round-robin across all ports as above.

## Test plan
- Single port 1 read, BURST_LENGTH=8, idle high -> acc_o high 1 cycle after req, 8 req_ack_o[1] pulses matching ack_i, done_o[1] one cycle after 8th ack, acc_o low.
- All three ports requesting continuously, rr=0 -> grant order 0,1,2,0,1,2; no port waits more than 2 bursts.
- sdram_idle_i low while req_i=3'b011 -> no grant until idle rises; then port 0 granted next edge.
- Port 2 write, drops req_i after 3 acks -> remaining 5 beats sel_o=2'b00, no further req_ack_o[2], no done_o[2], scheduler returns to IDLE.
- Assert sdram_rst_n low after 4th ack of a burst -> acc_o, gnt_o, req_ack_o zero immediately; after release first request gets full 8-beat burst from beat 0.
- With SDRAM_SCHED_PRIO0_EN, req_i=3'b111 held -> port 0 granted every burst; without it -> rotation as above.
